// File: rtl/int_ctrl.sv
// int_ctrl -- single-level interrupt controller for the CPU controller's INT path.
//
// Request lines are synchronised and edge-detected into pending bits; the
// highest-priority (lowest-index) pending line that is both unmasked and globally
// enabled is presented to the controller via int_req.  On int_ack the handler
// vector is latched and the controller stays in service until eoi; no nesting.
//
// Ports:
//   clk        system clock, all state on posedge
//   rst        synchronous active-high reset
//   irq_in     asynchronous request lines, rising edge requests service
//   in         data bus for configuration writes
//   cfg_we     configuration write strobe
//   cfg_sel    0=MASK (mask + gen in bit 15), 1=PEND_CLR, 2=PEND_SET, 3=ignored
//   int_req    interrupt request to the controller (registered)
//   int_ack    controller accepts the request, one-cycle strobe
//   eoi        end-of-interrupt strobe from the handler
//   stat_rd    selects status word instead of vector on out
//   out        vector, or {gen, in_service, 2'b0, svc_idx, pending} when stat_rd=1
//   in_service high while a handler is active (registered)
module int_ctrl #(
  parameter int unsigned N_IRQ     = 8,
  parameter logic [15:0] VEC_BASE  = 16'h0040,
  parameter int unsigned VEC_SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [15:0]      in,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  output logic             int_req,
  input  logic             int_ack,
  input  logic             eoi,
  input  logic             stat_rd,
  output logic [15:0]      out,
  output logic             in_service
);

  localparam logic [1:0] SEL_MASK     = 2'd0;
  localparam logic [1:0] SEL_PEND_CLR = 2'd1;
  localparam logic [1:0] SEL_PEND_SET = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SERV
  } state_t;

  state_t state, state_nxt;

  logic [N_IRQ-1:0] sync1, sync2, dly;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] pending, pending_nxt;
  logic [N_IRQ-1:0] mask;
  logic             gen;
  logic [N_IRQ-1:0] elig;
  logic [N_IRQ-1:0] sel_oh;
  logic [2:0]       sel;
  logic [2:0]       svc_idx;
  logic [15:0]      vec;
  logic             take;
  logic [7:0]       pend8;

  // Bits of the data bus that no register consumes.
  logic             unused_in;
  assign unused_in = ^in[14:N_IRQ];

  // Two-flop synchroniser followed by a delay flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      dly   <= '0;
    end else begin
      sync1 <= irq_in;
      sync2 <= sync1;
      dly   <= sync2;
    end
  end

  assign rise = sync2 & ~dly;

  // Eligibility and priority: lowest index wins.
  assign elig   = gen ? (pending & mask) : '0;
  assign sel_oh = elig & (~elig + 1'b1);

  always_comb begin
    sel = '0;
    for (int unsigned i = N_IRQ; i > 0; i--) begin
      if (elig[i-1]) sel = 3'(i - 1);
    end
  end

  // Next-state and acceptance decode.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (elig != '0) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        // A request withdrawn in the ack cycle is not accepted.
        if (elig == '0) begin
          state_nxt = ST_IDLE;
        end else if (int_ack) begin
          take      = 1'b1;
          state_nxt = ST_SERV;
        end
      end
      ST_SERV: begin
        if (eoi) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Pending update: acceptance and software clear first, then hardware
  // edges and software set, so a set always beats a clear of the same bit.
  always_comb begin
    pending_nxt = pending;
    if (take) pending_nxt = pending_nxt & ~sel_oh;
    if (cfg_we && cfg_sel == SEL_PEND_CLR) pending_nxt = pending_nxt & ~in[N_IRQ-1:0];
    pending_nxt = pending_nxt | rise;
    if (cfg_we && cfg_sel == SEL_PEND_SET) pending_nxt = pending_nxt | in[N_IRQ-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      int_req    <= 1'b0;
      in_service <= 1'b0;
    end else begin
      state      <= state_nxt;
      int_req    <= (state_nxt == ST_REQ);
      in_service <= (state_nxt == ST_SERV);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      mask    <= '0;
      gen     <= 1'b0;
      vec     <= '0;
      svc_idx <= '0;
    end else begin
      pending <= pending_nxt;
      if (cfg_we && cfg_sel == SEL_MASK) begin
        mask <= in[N_IRQ-1:0];
        gen  <= in[15];
      end
      if (take) begin
        vec     <= VEC_BASE + (16'(sel) << VEC_SHIFT);
        svc_idx <= sel;
      end
    end
  end

  always_comb begin
    pend8             = '0;
    pend8[N_IRQ-1:0]  = pending;
  end

  assign out = stat_rd ? {gen, in_service, 2'b00, 1'b0, svc_idx, pend8} : vec;

endmodule

// File: tb/tb_int_ctrl.sv
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  irq_in = '0;
  logic [15:0] in = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_sel = '0;
  logic        int_req;
  logic        int_ack = 1'b0;
  logic        eoi = 1'b0;
  logic        stat_rd = 1'b0;
  logic [15:0] out;
  logic        in_service;

  int n_checks = 0;
  int n_fail   = 0;

  int_ctrl #(.N_IRQ(8), .VEC_BASE(16'h0040), .VEC_SHIFT(2)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .in(in), .cfg_we(cfg_we),
    .cfg_sel(cfg_sel), .int_req(int_req), .int_ack(int_ack), .eoi(eoi),
    .stat_rd(stat_rd), .out(out), .in_service(in_service)
  );

  always #5 clk = ~clk;

  // Reference model: irq samples of the last three edges, pending/mask as
  // plain bit vectors, controller phase as an integer (0 idle, 1 asking, 2 serving).
  logic [7:0]  m_h1 = '0, m_h2 = '0, m_h3 = '0;
  logic [7:0]  m_pend = '0, m_mask = '0, m_np, m_elig, m_new;
  logic        m_gen = 1'b0;
  int          m_phase = 0;
  int          m_sel;
  logic [15:0] m_vec = '0;
  int          m_svc = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_h1 = '0; m_h2 = '0; m_h3 = '0;
      m_pend = '0; m_mask = '0; m_gen = 1'b0;
      m_phase = 0; m_vec = '0; m_svc = 0;
    end else begin
      m_new  = m_h2 & ~m_h3;
      m_elig = m_gen ? (m_pend & m_mask) : 8'h00;
      m_sel  = -1;
      for (int i = 7; i >= 0; i--) if (m_elig[i]) m_sel = i;
      m_np = m_pend;
      if (m_phase == 0) begin
        if (m_sel >= 0) m_phase = 1;
      end else if (m_phase == 1) begin
        if (m_sel < 0) m_phase = 0;
        else if (int_ack) begin
          m_vec = 16'h0040 + 16'(m_sel * 4);
          m_svc = m_sel;
          m_np[m_sel] = 1'b0;
          m_phase = 2;
        end
      end else begin
        if (eoi) m_phase = 0;
      end
      if (cfg_we && cfg_sel == 2'd0) begin m_mask = in[7:0]; m_gen = in[15]; end
      if (cfg_we && cfg_sel == 2'd1) m_np = m_np & ~in[7:0];
      m_np = m_np | m_new;
      if (cfg_we && cfg_sel == 2'd2) m_np = m_np | in[7:0];
      m_pend = m_np;
      m_h3 = m_h2; m_h2 = m_h1; m_h1 = irq_in;
    end
  end

  function automatic logic [15:0] m_out(input logic sr);
    logic [15:0] s;
    s = {m_gen, (m_phase == 2), 2'b00, 4'(m_svc), m_pend};
    return sr ? s : m_vec;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] s, input logic [15:0] d);
    cfg_we = 1'b1; cfg_sel = s; in = d;
    tick();
    cfg_we = 1'b0; in = '0;
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1; tick(); eoi = 1'b0;
  endtask

  task automatic wait_req(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      tick();
      if (int_req === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit ok;
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    n_checks++;
    if (int_req !== 1'b0 || in_service !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: int_req=%b in_service=%b required 0 0", int_req, in_service);
    end
    n_checks++;
    if (out !== 16'h0000) begin n_fail++; $display("FAIL reset_vec: got %h required 0000", out); end
    stat_rd = 1'b1; #1;
    n_checks++;
    if (out !== 16'h0000) begin n_fail++; $display("FAIL reset_stat: got %h required 0000", out); end
    stat_rd = 1'b0;
    ok = 1'b1;
  endtask

  task automatic test_single();
    wr(2'd0, 16'h80FF);
    irq_in[2] = 1'b1;
    for (int e = 0; e < 3; e++) begin
      tick();
      n_checks++;
      if (int_req !== 1'b0) begin n_fail++; $display("FAIL single_early edge%0d: int_req=%b required 0", e, int_req); end
    end
    tick();
    n_checks++;
    if (int_req !== 1'b1) begin n_fail++; $display("FAIL single_latency: int_req=%b required 1 after edge 3", int_req); end
    pulse_ack();
    n_checks++;
    if (out !== 16'h0048 || in_service !== 1'b1 || int_req !== 1'b0) begin
      n_fail++; $display("FAIL single_ack: out=%h in_service=%b int_req=%b required 0048 1 0", out, in_service, int_req);
    end
    stat_rd = 1'b1; #1;
    n_checks++;
    if (out !== 16'hC200 || out !== m_out(1'b1)) begin
      n_fail++; $display("FAIL single_stat: got %h required C200 (model %h)", out, m_out(1'b1));
    end
    stat_rd = 1'b0;
    irq_in[2] = 1'b0;
    pulse_eoi();
    n_checks++;
    if (in_service !== 1'b0) begin n_fail++; $display("FAIL single_eoi: in_service=%b required 0", in_service); end
    repeat (4) tick();
  endtask

  task automatic test_two_lines();
    bit ok;
    irq_in = 8'h22;
    wait_req(10, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL two_req1: int_req=%b required 1 within 10 cycles", int_req); end
    pulse_ack();
    n_checks++;
    if (out !== 16'h0044) begin n_fail++; $display("FAIL two_vec1: got %h required 0044", out); end
    pulse_eoi();
    n_checks++;
    if (int_req !== 1'b0) begin n_fail++; $display("FAIL two_eoi_idle: int_req=%b required 0", int_req); end
    tick();
    n_checks++;
    if (int_req !== 1'b1) begin n_fail++; $display("FAIL two_rereq: int_req=%b required 1", int_req); end
    pulse_ack();
    n_checks++;
    if (out !== 16'h0054) begin n_fail++; $display("FAIL two_vec2: got %h required 0054", out); end
    irq_in = '0;
    pulse_eoi();
    repeat (4) tick();
  endtask

  task automatic test_gen_gate();
    wr(2'd0, 16'h0008);
    wr(2'd2, 16'h0008);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (int_req !== 1'b0) begin n_fail++; $display("FAIL gen_off cyc%0d: int_req=%b required 0", i, int_req); end
      tick();
    end
    wr(2'd0, 16'h8008);
    n_checks++;
    if (int_req !== 1'b0) begin n_fail++; $display("FAIL gen_on_edge: int_req=%b required 0", int_req); end
    tick();
    n_checks++;
    if (int_req !== 1'b1) begin n_fail++; $display("FAIL gen_on_next: int_req=%b required 1", int_req); end
  endtask

  task automatic test_withdraw();
    wr(2'd1, 16'h0008);
    n_checks++;
    if (int_req !== 1'b1) begin n_fail++; $display("FAIL withdraw_edge: int_req=%b required 1", int_req); end
    tick();
    n_checks++;
    if (int_req !== 1'b0) begin n_fail++; $display("FAIL withdraw_drop: int_req=%b required 0", int_req); end
    pulse_ack();
    n_checks++;
    if (out !== 16'h0054 || in_service !== 1'b0 || int_req !== 1'b0) begin
      n_fail++; $display("FAIL withdraw_ack: out=%h in_service=%b int_req=%b required 0054 0 0", out, in_service, int_req);
    end
  endtask

  task automatic test_no_nest();
    bit ok;
    wr(2'd0, 16'h80FF);
    wr(2'd2, 16'h0004);
    wait_req(5, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL nest_req: int_req=%b required 1 within 5 cycles", int_req); end
    pulse_ack();
    n_checks++;
    if (out !== 16'h0048 || in_service !== 1'b1) begin
      n_fail++; $display("FAIL nest_ack: out=%h in_service=%b required 0048 1", out, in_service);
    end
    irq_in[0] = 1'b1; tick(); tick(); irq_in[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (int_req !== 1'b0 || in_service !== 1'b1) begin
        n_fail++; $display("FAIL nest_hold cyc%0d: int_req=%b in_service=%b required 0 1", i, int_req, in_service);
      end
    end
    pulse_eoi();
    tick();
    n_checks++;
    if (int_req !== 1'b1) begin n_fail++; $display("FAIL nest_after_eoi: int_req=%b required 1", int_req); end
    pulse_ack();
    n_checks++;
    if (out !== 16'h0040) begin n_fail++; $display("FAIL nest_vec0: got %h required 0040", out); end
    pulse_eoi();
    repeat (2) tick();
  endtask

  task automatic test_level_and_reset();
    bit ok;
    int extra;
    irq_in[4] = 1'b1;
    wait_req(10, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL level_req: int_req=%b required 1 within 10 cycles", int_req); end
    pulse_ack();
    n_checks++;
    if (out !== 16'h0050) begin n_fail++; $display("FAIL level_vec: got %h required 0050", out); end
    pulse_eoi();
    extra = 0;
    for (int i = 0; i < 46; i++) begin
      tick();
      if (int_req === 1'b1) extra++;
    end
    n_checks++;
    if (extra != 0) begin n_fail++; $display("FAIL level_rereq: %0d cycles with int_req, required 0", extra); end
    irq_in[4] = 1'b0;
    wr(2'd2, 16'h0001);
    wait_req(5, ok);
    pulse_ack();
    n_checks++;
    if (in_service !== 1'b1) begin n_fail++; $display("FAIL rst_pre: in_service=%b required 1", in_service); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_checks++;
    if (in_service !== 1'b0 || out !== 16'h0000 || int_req !== 1'b0) begin
      n_fail++; $display("FAIL rst_serv: in_service=%b out=%h int_req=%b required 0 0000 0", in_service, out, int_req);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      n_checks++;
      if (int_req !== (m_phase == 1) || in_service !== (m_phase == 2) || out !== m_out(stat_rd)) begin
        n_fail++;
        $display("FAIL random cyc%0d: int_req=%b in_service=%b out=%h required %b %b %h",
                 c, int_req, in_service, out, (m_phase == 1), (m_phase == 2), m_out(stat_rd));
      end
      for (int b = 0; b < 8; b++) if ($urandom_range(15) == 0) irq_in[b] = ~irq_in[b];
      cfg_we  = ($urandom_range(5) == 0);
      cfg_sel = 2'($urandom_range(3));
      in      = 16'($urandom);
      if ($urandom_range(3) != 0) in[15] = 1'b1;
      int_ack = ($urandom_range(2) == 0);
      eoi     = ($urandom_range(4) == 0);
      stat_rd = ($urandom_range(1) == 0);
      rst     = ($urandom_range(199) == 0);
      tick();
    end
    cfg_we = 1'b0; int_ack = 1'b0; eoi = 1'b0; rst = 1'b0; stat_rd = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_two_lines();
    test_gen_gate();
    test_withdraw();
    test_no_nest();
    test_level_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
